// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink pattern sequencer.
// Divider constants target a 50 MHz system clock.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_SHIFT  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF,
        S_BLINK,
        S_SHIFT,
        S_BNC_UP,
        S_BNC_DN
    } seq_state_e;

    localparam int DIV_1HZ   = 25_000_000;
    localparam int DIV_10HZ  = 2_500_000;
    localparam int DIV_100HZ = 250_000;

    function automatic seq_state_e entry_state(mode_e m);
        seq_state_e s;
        s = S_OFF;
        unique case (m)
            MODE_OFF:    s = S_OFF;
            MODE_BLINK:  s = S_BLINK;
            MODE_SHIFT:  s = S_SHIFT;
            MODE_BOUNCE: s = S_BNC_UP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/blink_pattern_seq_rise_det.sv
// Rising-edge detector; the history flop resets high so an input
// already high when reset is released is not seen as an edge.
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk) begin
        if (!rst_n) q <= 1'b1;
        else        q <= d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/blink_pattern_seq.sv
// LED pattern sequencer stepped by the divided slow clock or step_i.
// Optional PWM dimming is built when BLINK_SEQ_PWM_EN is defined.
module blink_pattern_seq
    import blink_pkg::*;
#(
    parameter int N_LEDS   = 8,
    parameter int PWM_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick_in,
    input  logic                      step_i,
    input  logic                      run_i,
    input  logic [1:0]                mode_i,
    input  logic [PWM_BITS-1:0]       duty_i,
    output logic [N_LEDS-1:0]         leds_o,
    output logic [$clog2(N_LEDS)-1:0] pos_o,
    output logic                      tick_o
);

    localparam int PW = $clog2(N_LEDS);
    localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] POS_TURN = PW'(N_LEDS - 2);
    localparam logic [N_LEDS-1:0] LED0 = N_LEDS'(1);

    logic tick_rise;
    logic step_rise;
    logic adv;

    rise_det u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (tick_in),
        .rise (tick_rise)
    );

    rise_det u_step (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (step_i),
        .rise (step_rise)
    );

    assign adv = run_i ? tick_rise : step_rise;

    mode_e       mode_q;
    mode_e       mode_in;
    seq_state_e  state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic        phase_q, phase_d;
    logic        tick_d;
    logic [N_LEDS-1:0] pattern;
    logic [N_LEDS-1:0] leds_q;
    logic        tick_q;
    logic        lit;

    assign mode_in = mode_e'(mode_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            state_q <= S_OFF;
            pos_q   <= '0;
            phase_q <= 1'b0;
            leds_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_in;
            state_q <= state_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            leds_q  <= pattern & {N_LEDS{lit}};
            tick_q  <= tick_d;
        end
    end

    // A mode change re-seeds the pattern and swallows any coincident advance.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        phase_d = phase_q;
        tick_d  = 1'b0;
        if (mode_in != mode_q) begin
            state_d = entry_state(mode_in);
            pos_d   = '0;
            phase_d = 1'b0;
        end else if (adv) begin
            unique case (state_q)
                S_OFF: ;
                S_BLINK: begin
                    phase_d = ~phase_q;
                    tick_d  = 1'b1;
                end
                S_SHIFT: begin
                    pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                    tick_d = 1'b1;
                end
                S_BNC_UP: begin
                    pos_d  = pos_q + 1'b1;
                    tick_d = 1'b1;
                    if (pos_q == POS_TURN) state_d = S_BNC_DN;
                end
                S_BNC_DN: begin
                    pos_d  = pos_q - 1'b1;
                    tick_d = 1'b1;
                    if (pos_q == PW'(1)) state_d = S_BNC_UP;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pattern = '0;
        unique case (state_d)
            S_OFF:   pattern = '0;
            S_BLINK: pattern = {N_LEDS{phase_d}};
            default: pattern = LED0 << pos_d;
        endcase
    end

`ifdef BLINK_SEQ_PWM_EN
    logic [PWM_BITS-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_q + 1'b1;
    end

    assign lit = (pc_q < duty_i);
`else
    logic duty_unused;

    assign duty_unused = ^duty_i;
    assign lit = 1'b1;
`endif

    assign leds_o = leds_q;
    assign pos_o  = pos_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_blink_pattern_seq.sv
// Randomised and directed bench for blink_pattern_seq (N_LEDS=4),
// compared every cycle against a sequence-index reference model.
module tb_blink_pattern_seq;

    localparam int N = 4;
`ifdef BLINK_SEQ_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       step_i;
    logic       run_i;
    logic [1:0] mode_i;
    logic [3:0] duty_i;
    logic [3:0] leds_o;
    logic [1:0] pos_o;
    logic       tick_o;

    int checks = 0;
    int errors = 0;
    int tcnt   = 4;

    blink_pattern_seq #(.N_LEDS(N), .PWM_BITS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_in(tick_in),
        .step_i (step_i),
        .run_i  (run_i),
        .mode_i (mode_i),
        .duty_i (duty_i),
        .leds_o (leds_o),
        .pos_o  (pos_o),
        .tick_o (tick_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: each mode walks an index; bounce folds a 0..2N-3 cycle.
    int m_mode, m_idx, m_pos, m_pc;
    bit m_pt, m_ps, m_tick, m_adv, m_lit;
    logic [3:0] m_leds;

    function automatic int pos_of(input int mode, input int idx);
        if (mode == 2) return idx;
        if (mode == 3) return (idx < N) ? idx : (2 * N - 2 - idx);
        return 0;
    endfunction

    function automatic logic [3:0] pat_of(input int mode, input int idx);
        logic [3:0] one;
        one = 4'b0001;
        if (mode == 0) return 4'b0000;
        if (mode == 1) return (idx != 0) ? 4'b1111 : 4'b0000;
        return one << pos_of(mode, idx);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_idx = 0; m_pt = 1; m_ps = 1;
            m_tick = 0; m_leds = 0; m_pc = 0;
        end else begin
            m_adv = run_i ? (tick_in && !m_pt) : (step_i && !m_ps);
            m_pt = tick_in;
            m_ps = step_i;
            m_tick = 0;
            if (int'(mode_i) != m_mode) begin
                m_mode = int'(mode_i);
                m_idx = 0;
            end else if (m_adv && m_mode != 0) begin
                m_tick = 1;
                case (m_mode)
                    1: m_idx = 1 - m_idx;
                    2: m_idx = (m_idx + 1) % N;
                    default: m_idx = (m_idx + 1) % (2 * N - 2);
                endcase
            end
            m_lit = PWM ? (m_pc < int'(duty_i)) : 1'b1;
            m_pc = (m_pc + 1) % 16;
            m_leds = m_lit ? pat_of(m_mode, m_idx) : 4'b0000;
        end
        m_pos = pos_of(m_mode, m_idx);
        #1;
        chk("leds", int'(leds_o), int'(m_leds));
        chk("pos", int'(pos_o), m_pos);
        chk("tick", int'(tick_o), int'(m_tick));
    end

    // One clk: tick_in is an 8-cycle square wave updated at negedge.
    task automatic clk1();
        @(negedge clk);
        tcnt++;
        tick_in = (tcnt % 8) >= 4;
    endtask

    task automatic to_rise();
        do clk1(); while ((tcnt % 8) != 4);
    endtask

    initial begin
        bit found;
        int cnt;
        int duties[3];
        duties[0] = 0; duties[1] = 4; duties[2] = 15;

        rst_n = 0; tick_in = 1; step_i = 0; run_i = 1;
        mode_i = 2'b00; duty_i = 4'd15;
        repeat (3) clk1();
        chk("rst_leds", int'(leds_o), 0);
        chk("rst_pos", int'(pos_o), 0);
        chk("rst_tick", int'(tick_o), 0);

        rst_n = 1; mode_i = 2'b10;
        repeat (44) clk1();

        mode_i = 2'b11;
        repeat (72) clk1();

        mode_i = 2'b01;
        repeat (40) clk1();
        to_rise();
        mode_i = 2'b10;
        @(posedge clk); #2;
        chk("sw_tick", int'(tick_o), 0);
        chk("sw_pos", int'(pos_o), 0);
        chk("sw_leds", int'(leds_o), int'(m_leds));

        run_i = 0;
        repeat (24) clk1();
        repeat (3) begin
            step_i = 1; clk1(); clk1();
            step_i = 0; clk1(); clk1();
        end
        chk("step_pos", int'(pos_o), 3);
        to_rise();
        step_i = 1;
        @(posedge clk); #2;
        chk("co_tick", int'(tick_o), 1);
        chk("co_pos", int'(pos_o), 0);
        clk1(); step_i = 0;
        repeat (4) clk1();
        run_i = 1;
        repeat (40) begin
            step_i = ~step_i;
            clk1();
        end
        step_i = 0;

        mode_i = 2'b11;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            clk1();
            if (m_mode == 3 && m_idx == 4) found = 1;
        end
        chk("find_bnc_dn", int'(found), 1);
        rst_n = 0;
        @(posedge clk); #2;
        chk("mid_rst_leds", int'(leds_o), 0);
        chk("mid_rst_pos", int'(pos_o), 0);
        chk("mid_rst_tick", int'(tick_o), 0);
        clk1(); rst_n = 1;
        repeat (40) clk1();

        mode_i = 2'b01;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            clk1();
            if (m_mode == 1 && m_idx == 1) found = 1;
        end
        chk("find_lit", int'(found), 1);
        run_i = 0;
        foreach (duties[k]) begin
            duty_i = 4'(duties[k]);
            cnt = 0;
            repeat (16) begin
                @(posedge clk); #2;
                if (leds_o == 4'b1111) cnt++;
            end
            chk("pwm_lit", cnt, PWM ? duties[k] : 16);
            @(negedge clk);
        end

        for (int i = 0; i < 1500; i++) begin
            clk1();
            if ($urandom_range(0, 9) == 0) run_i = $urandom_range(0, 1);
            step_i = $urandom_range(0, 1);
            if ($urandom_range(0, 39) == 0) mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) duty_i = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1;
        repeat (4) clk1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
